// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and helpers for the convolution accelerator output path
package conv_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_RUN, TX_DONE} tx_state_t;

    localparam int K_MIN = 2;

    // Operands arrive zero-extended so the product cannot go negative for any legal K.
    function automatic logic [15:0] conv_out_count(input logic [15:0] r, input logic [15:0] c,
                                                    input logic [15:0] k);
        return (r - k + 16'd1) * (c - k + 16'd1);
    endfunction

endpackage

// File: rtl/conv_output_tx_if.sv
// rtl/conv_output_tx_if.sv - result input stream and AXIS output bundle of conv_output_tx
interface conv_output_tx_if #(
    parameter int OUTW = 48
);
    logic [OUTW-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [OUTW-1:0] AXIS_TDATA;
    logic            AXIS_TVALID;
    logic            AXIS_TLAST;
    logic            AXIS_TUSER;
    logic            AXIS_TREADY;

    modport master (
        input  in_data, in_valid, AXIS_TREADY,
        output in_ready, AXIS_TDATA, AXIS_TVALID, AXIS_TLAST, AXIS_TUSER
    );

    modport slave (
        output in_data, in_valid, AXIS_TREADY,
        input  in_ready, AXIS_TDATA, AXIS_TVALID, AXIS_TLAST, AXIS_TUSER
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - registered FIFO, head word presented directly from storage
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/conv_output_tx.sv
// rtl/conv_output_tx.sv - AXIS master sending one (R-K+1)x(C-K+1) result frame per start
// CONV_TX_ROWMARK_EN: drive AXIS_TUSER on the last beat of every output row.
module conv_output_tx
    import conv_pkg::*;
#(
    parameter int OUTW  = 48,
    parameter int R     = 9,
    parameter int C     = 8,
    parameter int MAXK  = 4,
    parameter int DEPTH = 8,
    localparam int K_BITS   = $clog2(MAXK + 1),
    localparam int CNT_BITS = $clog2(R * C + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [K_BITS-1:0] K,
    conv_output_tx_if.master  bus,
    output logic              busy,
    output logic              frame_done
);
    tx_state_t             state, state_n;
    logic [CNT_BITS-1:0]   total, in_cnt, out_cnt, total_calc;
    logic                  start_ok, run, full, empty, push, pop, last_beat;
    logic [$clog2(DEPTH+1)-1:0] fifo_count_unused;

    assign start_ok   = start && (K >= K_BITS'(K_MIN)) && (K <= K_BITS'(MAXK));
    assign total_calc = CNT_BITS'(conv_out_count(16'(R), 16'(C), 16'(K)));
    assign run        = (state == TX_RUN);

    assign bus.in_ready    = run && !full && (in_cnt < total);
    assign bus.AXIS_TVALID = run && !empty;
    assign push            = bus.in_valid && bus.in_ready;
    assign pop             = bus.AXIS_TVALID && bus.AXIS_TREADY;
    assign last_beat       = (out_cnt == total - CNT_BITS'(1));
    assign bus.AXIS_TLAST  = bus.AXIS_TVALID && last_beat;

    sync_fifo #(.WIDTH(OUTW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (bus.in_data),
        .pop   (pop),
        .rdata (bus.AXIS_TDATA),
        .full  (full),
        .empty (empty),
        .count (fifo_count_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= TX_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            TX_IDLE: if (start_ok)         state_n = TX_RUN;
            TX_RUN:  if (pop && last_beat) state_n = TX_DONE;
            TX_DONE:                       state_n = TX_IDLE;
            default:                       state_n = TX_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != TX_IDLE);
        frame_done = (state == TX_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (state == TX_IDLE && start_ok) begin
            total   <= total_calc;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (push) in_cnt  <= in_cnt + CNT_BITS'(1);
            if (pop)  out_cnt <= out_cnt + CNT_BITS'(1);
        end
    end

`ifdef CONV_TX_ROWMARK_EN
    logic [CNT_BITS-1:0] rowlen, col_cnt;
    logic                row_end;

    assign row_end        = (col_cnt == rowlen - CNT_BITS'(1));
    assign bus.AXIS_TUSER = bus.AXIS_TVALID && row_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            rowlen  <= '0;
            col_cnt <= '0;
        end else if (state == TX_IDLE && start_ok) begin
            rowlen  <= CNT_BITS'(C) - CNT_BITS'(K) + CNT_BITS'(1);
            col_cnt <= '0;
        end else if (pop) begin
            col_cnt <= row_end ? '0 : col_cnt + CNT_BITS'(1);
        end
    end
`else
    assign bus.AXIS_TUSER = 1'b0;
`endif
endmodule

// File: tb/tb_conv_output_tx.sv
// tb/tb_conv_output_tx.sv - directed self-checking bench for conv_output_tx
module tb_conv_output_tx;
    localparam int OUTW = 48, R = 9, C = 8, MAXK = 4, DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [2:0] K;
    logic       busy, frame_done;
    int         n_checks = 0;
    int         n_fail   = 0;

    conv_output_tx_if #(.OUTW(OUTW)) bus ();

    conv_output_tx #(.OUTW(OUTW), .R(R), .C(C), .MAXK(MAXK), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .K          (K),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // total/rowlen are hand-computed by the caller; hold forces TREADY low for that many cycles;
    // abort_at > 0 applies reset once that many beats have left.
    task automatic run_frame(input int k, input int total, input int rowlen, input bit rnd,
                             input int hold, input int abort_at, input logic [47:0] base);
        int pushed = 0, beats = 0, cyc = 0;
        bit stall = 1'b0, cap_checked = 1'b0, late_done = 1'b0;
        logic [47:0] prev_data = '0;
        logic prev_last = 1'b0, exp_user;
        start = 1'b1;
        K     = k[2:0];
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (beats < total && cyc < 3000 && !(abort_at > 0 && beats >= abort_at)) begin
            bus.in_valid    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data     = base + 48'(pushed + 1);
            bus.AXIS_TREADY = (cyc < hold) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            if (hold > 0 && cyc == hold) begin
                check("hold_pushes", pushed, DEPTH);
                check("hold_in_ready", bus.in_ready, 0);
                check("hold_head", bus.AXIS_TDATA, base + 48'd1);
            end
            if (stall) begin
                check("stall_tdata", bus.AXIS_TDATA, prev_data);
                check("stall_tlast", bus.AXIS_TLAST, prev_last);
            end
            if (pushed == total && !cap_checked) begin
                check("no_overaccept", bus.in_ready, 0);
                cap_checked = 1'b1;
            end
            if (bus.AXIS_TVALID && bus.AXIS_TREADY) begin
                exp_user = ((beats + 1) % rowlen) == 0;
`ifndef CONV_TX_ROWMARK_EN
                exp_user = 1'b0;
`endif
                check("tdata", bus.AXIS_TDATA, base + 48'(beats + 1));
                check("tlast", bus.AXIS_TLAST, beats == total - 1);
                check("tuser", bus.AXIS_TUSER, exp_user);
                beats++;
            end
            stall     = bus.AXIS_TVALID && !bus.AXIS_TREADY;
            prev_data = bus.AXIS_TDATA;
            prev_last = bus.AXIS_TLAST;
            if (bus.in_valid && bus.in_ready) pushed++;
            cyc++;
            @(negedge clk);
        end
        bus.in_valid    = 1'b0;
        bus.AXIS_TREADY = 1'b0;
        if (abort_at > 0) begin
            check("abort_reached", beats, abort_at);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("abort_tvalid", bus.AXIS_TVALID, 0);
            check("abort_busy", busy, 0);
            check("abort_frame_done", frame_done, 0);
            repeat (4) begin
                @(negedge clk);
                late_done = late_done | frame_done;
            end
            check("abort_no_late_done", late_done, 0);
        end else begin
            check("beats_sent", beats, total);
            check("frame_done_pulse", frame_done, 1);
            check("done_tvalid", bus.AXIS_TVALID, 0);
            @(negedge clk);
            check("frame_done_clear", frame_done, 0);
            check("busy_idle", busy, 0);
        end
    endtask

    task automatic try_bad_k(input int k);
        start = 1'b1;
        K     = k[2:0];
        @(negedge clk);
        start = 1'b0;
        check("bad_k_busy", busy, 0);
        check("bad_k_in_ready", bus.in_ready, 0);
        @(negedge clk);
        check("bad_k_still_idle", busy, 0);
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        K               = '0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.AXIS_TREADY = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_tvalid", bus.AXIS_TVALID, 0);
        check("rst_tlast", bus.AXIS_TLAST, 0);
        check("rst_tuser", bus.AXIS_TUSER, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        reset = 1'b0;
        @(negedge clk);

        run_frame(3, 42, 6, 1'b0, 0, 0, 48'h0);
        run_frame(4, 30, 5, 1'b0, 20, 0, 48'h0000_1000_0000);
        run_frame(2, 56, 7, 1'b1, 0, 0, 48'hF000_0000_0000);
        try_bad_k(1);
        try_bad_k(5);
        run_frame(2, 56, 7, 1'b0, 0, 0, 48'h7FFF_FFFF_0000);
        run_frame(3, 42, 6, 1'b0, 0, 10, 48'h0000_0000_0100);
        run_frame(3, 42, 6, 1'b0, 0, 0, 48'h8000_0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
